ex_ctrl: RTL

Pipeline controller for the execute stage of the five-stage RV32I core. It turns the EX-stage branch outcome into a PC redirect and a front-end flush, inserts load-use bubbles, and sequences the iterative multiply/divide unit that sits beside the ALU with a start pulse, a pipeline hold and a timeout. The block sits between the EX-stage datapath and the IF/ID/EX pipeline registers and drives their stall and flush enables.

---
 rtl/core_pkg.sv | 20 ++
 rtl/ex_ctrl_if.sv | 41 ++++
 rtl/ex_ctrl_sat_counter.sv | 33 +++
 rtl/ex_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types for the execute-stage controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ex_ctrl_state_t FSM encoding, MD_TIMEOUT default, counter widths.
package core_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        LU_HOLD = 2'd2,
        MD_WAIT = 2'd3
    } ex_ctrl_state_t;

    // Default number of MD_WAIT cycles before a mul/div op is abandoned.
    localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

    localparam int unsigned FLUSH_CNT_W = 3;
    localparam int unsigned MD_CNT_W    = 8;

endpackage

// File: rtl/ex_ctrl_if.sv
// EX-stage control bundle: branch/hazard/mul-div requests in, stall/flush/redirect out.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall_* outputs are the backpressure to the pipeline registers.
// Modports: slave = ex_ctrl (consumes EX requests), master = EX datapath / pipeline side.
interface ex_ctrl_if;

    logic        br_taken_i;
    logic [31:0] new_pc_i;
    logic        ld_use_i;
    logic        md_req_i;
    logic        md_done_i;

    logic        pc_sel_o;
    logic [31:0] pc_redirect_o;
    logic        stall_if_o;
    logic        stall_id_o;
    logic        stall_ex_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        flush_ex_o;
    logic        md_go_o;
    logic        md_err_o;
    logic        busy_o;

    modport slave (
        input  br_taken_i, new_pc_i, ld_use_i, md_req_i, md_done_i,
        output pc_sel_o, pc_redirect_o,
        output stall_if_o, stall_id_o, stall_ex_o,
        output flush_if_o, flush_id_o, flush_ex_o,
        output md_go_o, md_err_o, busy_o
    );

    modport master (
        output br_taken_i, new_pc_i, ld_use_i, md_req_i, md_done_i,
        input  pc_sel_o, pc_redirect_o,
        input  stall_if_o, stall_id_o, stall_ex_o,
        input  flush_if_o, flush_id_o, flush_ex_o,
        input  md_go_o, md_err_o, busy_o
    );

endinterface

// File: rtl/ex_ctrl_sat_counter.sv
// Saturating event counter: increments once per cycle with inc_i, sticks at all-ones.
// Latency: count reflects an event one cycle after inc_i.
// Backpressure: none; inc_i is sampled every cycle.
// Ports: clk_i, rst_n_i (async active-low), inc_i, cnt_o[W-1:0].
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_ctrl.sv
// EX-stage pipeline controller: branch redirect/flush, load-use bubble, mul/div sequencing.
// Latency: redirect, stalls and flushes are combinational; md_err_o is decoded from flops only.
// Backpressure: holds IF/ID(/EX) via stall_*_o for load-use (1 cycle) and mul/div (1 + wait cycles).
// Ports: clk_i, rst_n_i, bus (ex_ctrl_if.slave); with EX_CTRL_PERF_EN defined also
//        perf_stall_o / perf_flush_o (32-bit saturating cycle/redirect counters).
module ex_ctrl
    import core_pkg::*;
#(
    parameter int unsigned IMEM_LAT   = 1,
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ex_ctrl_if.slave    bus
`ifdef EX_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(IMEM_LAT);
    localparam logic [MD_CNT_W-1:0]    MD_LOAD    = MD_CNT_W'(MD_TIMEOUT);
    localparam bit                     HAS_FLUSH  = (IMEM_LAT != 0);

    ex_ctrl_state_t         state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [MD_CNT_W-1:0]    md_cnt_q, md_cnt_d;

    logic pc_sel;
    logic stall_if, stall_id, stall_ex;
    logic flush_if, flush_id, flush_ex;
    logic md_go;
    logic md_timeout;

    // Timeout is a pure function of state and counter, so md_err_o has no
    // input-to-output path. A done pulse that lands on the expiry cycle is
    // treated as too late and the op is still abandoned.
    assign md_timeout = (state_q == MD_WAIT) && (md_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        md_cnt_d    = md_cnt_q;
        pc_sel      = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        md_go       = 1'b0;

        case (state_q)
            // LU_HOLD behaves like RUN except that ld_use_i is masked, so the
            // same load cannot produce a second bubble.
            RUN, LU_HOLD: begin
                state_d = RUN;
                if (bus.br_taken_i) begin
                    pc_sel   = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    if (HAS_FLUSH) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (bus.md_req_i) begin
                    md_go    = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    md_cnt_d = MD_LOAD;
                    state_d  = MD_WAIT;
                end else if (bus.ld_use_i && (state_q == RUN)) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = LU_HOLD;
                end
            end

            // Wrong-path fetches still arriving from synchronous IMEM; EX holds
            // a bubble so its requests are ignored here.
            FLUSH: begin
                flush_if    = 1'b1;
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q <= 1) begin
                    state_d = RUN;
                end
            end

            MD_WAIT: begin
                if (md_timeout) begin
                    flush_ex = 1'b1;
                    state_d  = RUN;
                end else if (bus.md_done_i) begin
                    // Stalls drop in the done cycle so the result advances.
                    state_d = RUN;
                end else begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    // Combinational outputs are qualified with reset so every output reads 0
    // while rst_n_i is low, regardless of what EX is presenting.
    assign bus.pc_sel_o      = rst_n_i & pc_sel;
    assign bus.pc_redirect_o = (rst_n_i & pc_sel) ? bus.new_pc_i : 32'h0;
    assign bus.stall_if_o    = rst_n_i & stall_if;
    assign bus.stall_id_o    = rst_n_i & stall_id;
    assign bus.stall_ex_o    = rst_n_i & stall_ex;
    assign bus.flush_if_o    = rst_n_i & flush_if;
    assign bus.flush_id_o    = rst_n_i & flush_id;
    assign bus.flush_ex_o    = rst_n_i & flush_ex;
    assign bus.md_go_o       = rst_n_i & md_go;
    assign bus.md_err_o      = md_timeout;
    assign bus.busy_o        = (state_q != RUN);

    // Branch and mul/div both originate from the single instruction in EX.
    br_md_exclusive: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(bus.br_taken_i && bus.md_req_i)
    );

`ifdef EX_CTRL_PERF_EN
    sat_counter #(.W(32)) u_perf_stall (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bus.stall_id_o),
        .cnt_o   (perf_stall_o)
    );

    sat_counter #(.W(32)) u_perf_flush (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bus.pc_sel_o),
        .cnt_o   (perf_flush_o)
    );
`endif

endmodule
